// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all downstream domain resets for HOLD_CYCLES edges,
// then releases the enabled domains one at a time in ascending index order,
// STAGGER_CYCLES edges apart. A software request in RUN restarts the sequence.
module rst_seq_ctrl #(
    parameter int NUM_DOM        = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sw_rst_req,
    input  logic [NUM_DOM-1:0] i_dom_en,
    output logic [NUM_DOM-1:0] o_dom_rst,
    output logic               o_sw_rst_ack,
    output logic               o_busy,
    output logic               o_all_released
);

    localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    // Keep at least one bit so HOLD_CYCLES == STAGGER_CYCLES == 1 still elaborates.
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = $clog2(NUM_DOM + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOM - 1);

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_DOM-1:0] mask_q, mask_d;
    logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               all_rel_q, all_rel_d;

    logic [NUM_DOM-1:0] cur_onehot;
    logic               cur_en;
    logic               step;

    // Decode the current domain index to a one-hot select without a wide part-select.
    always_comb begin
        cur_onehot = '0;
        for (int k = 0; k < NUM_DOM; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_onehot[k] = 1'b1;
            end
        end
        cur_en = |(cur_onehot & mask_q);
    end

    // Next-state logic for the HOLD -> RELEASE -> RUN sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        dom_rst_d = dom_rst_q;
        ack_d     = 1'b0;
        step      = 1'b0;

        case (state_q)
            ST_HOLD: begin
                dom_rst_d = '1;
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    // Enable mask is captured only here and frozen for the whole pass.
                    mask_d  = i_dom_en;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (cur_en) begin
                    if (cnt_q == STAGGER_LAST) begin
                        dom_rst_d = dom_rst_q & ~cur_onehot;
                        step      = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Disabled domain still consumes one edge and stays in reset.
                    step = 1'b1;
                end
                if (step) begin
                    idx_d = idx_q + IDX_W'(1);
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (i_sw_rst_req) begin
                    dom_rst_d = '1;
                    ack_d     = 1'b1;
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d   = ST_HOLD;
                cnt_d     = '0;
                idx_d     = '0;
                dom_rst_d = '1;
            end
        endcase

        // Status flags follow the next state so they change on the same edge as the FSM.
        busy_d    = (state_d != ST_RUN);
        all_rel_d = (state_d == ST_RUN);
    end

    // State and output registers; reset forces every domain back into reset at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            mask_q    <= '0;
            dom_rst_q <= '1;
            ack_q     <= 1'b0;
            busy_q    <= 1'b1;
            all_rel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
            dom_rst_q <= dom_rst_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            all_rel_q <= all_rel_d;
        end
    end

    assign o_dom_rst      = dom_rst_q;
    assign o_sw_rst_ack   = ack_q;
    assign o_busy         = busy_q;
    assign o_all_released = all_rel_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl at default parameters.
// Expected outputs per edge come from a table of hand-derived release edges.
module tb_rst_seq_ctrl;

    logic       i_clk;
    logic       i_rst;
    logic       i_sw_rst_req;
    logic [3:0] i_dom_en;
    logic [3:0] o_dom_rst;
    logic       o_sw_rst_ack;
    logic       o_busy;
    logic       o_all_released;

    int checks   = 0;
    int failures = 0;

    // Packed observation: {dom_rst[3:0], busy, all_released, ack}
    logic [6:0] exp_q[$];

    typedef struct {
        logic [3:0] mask;
        int         r0;
        int         r1;
        int         r2;
        int         r3;
        int         run_edge;
    } vec_t;

    vec_t tbl[6];

    rst_seq_ctrl #(
        .NUM_DOM       (4),
        .HOLD_CYCLES   (8),
        .STAGGER_CYCLES(4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_sw_rst_req  (i_sw_rst_req),
        .i_dom_en      (i_dom_en),
        .o_dom_rst     (o_dom_rst),
        .o_sw_rst_ack  (o_sw_rst_ack),
        .o_busy        (o_busy),
        .o_all_released(o_all_released)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [6:0] obs();
        return {o_dom_rst, o_busy, o_all_released, o_sw_rst_ack};
    endfunction

    function automatic logic [6:0] expect_at(input int n, input vec_t v);
        logic [3:0] dom;
        int         rel[4];
        logic       all;
        rel[0] = v.r0;
        rel[1] = v.r1;
        rel[2] = v.r2;
        rel[3] = v.r3;
        for (int k = 0; k < 4; k++) begin
            dom[k] = (rel[k] == 0) || (n < rel[k]);
        end
        all = (n >= v.run_edge);
        return {dom, ~all, all, 1'b0};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got dom_rst/busy/all/ack=%b_%b_%b_%b want %b_%b_%b_%b", name,
                     act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Pop the oldest scoreboard entry and compare against the current DUT outputs.
    task automatic pop_check(input string name);
        logic [6:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, obs(), e);
        end
    endtask

    // Assert reset away from a clock edge, confirm the forced values, release at negedge.
    task automatic apply_reset(input string name);
        i_rst = 1'b1;
        #1;
        check(name, obs(), {4'hF, 1'b1, 1'b0, 1'b0});
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // Step edges 1..nmax of a sequence; optional sw pulse and mask toggles that must be ignored.
    task automatic run_scenario(input string name, input vec_t v, input int nmax,
                                input int sw_edge, input logic toggle);
        for (int n = 1; n <= nmax; n++) begin
            if (sw_edge > 0 && n == sw_edge) i_sw_rst_req = 1'b1;
            exp_q.push_back(expect_at(n, v));
            @(posedge i_clk);
            #1;
            if (sw_edge > 0 && n == sw_edge) i_sw_rst_req = 1'b0;
            if (toggle && (n == 9 || n == 26)) i_dom_en = ~v.mask;
            pop_check($sformatf("%s_e%0d", name, n));
        end
    endtask

    initial begin
        tbl[0] = '{mask: 4'b1111, r0: 12, r1: 16, r2: 20, r3: 24, run_edge: 24};
        tbl[1] = '{mask: 4'b1010, r0: 0,  r1: 13, r2: 0,  r3: 18, run_edge: 18};
        tbl[2] = '{mask: 4'b0000, r0: 0,  r1: 0,  r2: 0,  r3: 0,  run_edge: 12};
        tbl[3] = '{mask: 4'b0001, r0: 12, r1: 0,  r2: 0,  r3: 0,  run_edge: 15};
        tbl[4] = '{mask: 4'b1000, r0: 0,  r1: 0,  r2: 0,  r3: 15, run_edge: 15};
        tbl[5] = '{mask: 4'b0110, r0: 0,  r1: 13, r2: 17, r3: 0,  run_edge: 18};

        i_rst        = 1'b0;
        i_sw_rst_req = 1'b0;
        i_dom_en     = 4'b0000;
        #1;

        // Table-driven sequences: sw request during RELEASE and mask toggles are ignored.
        for (int s = 0; s < 6; s++) begin
            i_dom_en = tbl[s].mask;
            apply_reset($sformatf("reset_s%0d", s));
            run_scenario($sformatf("seq%0d", s), tbl[s], 30, 10, 1'b1);
        end

        // Software reset accepted in RUN, then the full sequence repeats from HOLD.
        i_dom_en = 4'b1111;
        apply_reset("reset_sw");
        run_scenario("sw_pre", tbl[0], 26, 0, 1'b0);
        i_sw_rst_req = 1'b1;
        exp_q.push_back({4'hF, 1'b1, 1'b0, 1'b1});
        @(posedge i_clk);
        #1;
        i_sw_rst_req = 1'b0;
        pop_check("sw_accept");
        run_scenario("sw_post", tbl[0], 26, 0, 1'b0);

        // Request held high through HOLD/RELEASE is taken on the first RUN edge.
        i_dom_en = 4'b0000;
        apply_reset("reset_held");
        i_sw_rst_req = 1'b1;
        run_scenario("held", tbl[2], 12, 0, 1'b0);
        exp_q.push_back({4'hF, 1'b1, 1'b0, 1'b1});
        @(posedge i_clk);
        #1;
        i_sw_rst_req = 1'b0;
        pop_check("held_accept");
        exp_q.push_back({4'hF, 1'b1, 1'b0, 1'b0});
        @(posedge i_clk);
        #1;
        pop_check("held_ack_drop");

        // Asynchronous reset after dom0 released: forced without a clock, then restart.
        i_dom_en = 4'b1111;
        apply_reset("reset_mid");
        run_scenario("mid_pre", tbl[0], 14, 0, 1'b0);
        #2;
        apply_reset("async_rst_mid");
        run_scenario("mid_post", tbl[0], 26, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
